// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: definitions shared by the AXI4-Lite write-path arbiter and
// the round-robin pick logic.
//   - AXI response codes (RESP_OKAY .. RESP_DECERR)
//   - write arbiter FSM state encoding (wr_state_e)
//   - onehot_idx: converts a 2-bit one-hot grant into a master index
package axi4_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ADDR_DATA = 2'd1,
      RESP      = 2'd2
   } wr_state_e;

   // Index of the granted master. Only a clean 2'b10 maps to master 1, so an
   // empty or corrupted grant falls back to master 0.
   function automatic logic onehot_idx(input logic [1:0] oh);
      return oh[1] & ~oh[0];
   endfunction

endpackage

// File: rtl/axi4_lite_wr_arbiter_rr.sv
// rr_arbiter2: combinational two-requester round-robin pick.
//   req  in  2  request per requester
//   last in  1  index of the requester served most recently
//   win  out 2  one-hot winner, 2'b00 when nobody requests
// When both request, the requester that was not served last wins. The block
// has no state of its own, so it can be reused for the read-path arbiter.
module rr_arbiter2
   import axi4_lite_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] win
);

   // Pick the winner from the request pattern and the last-served index.
   always_comb begin
      win = 2'b00;
      case (req)
         2'b01:   win = 2'b01;
         2'b10:   win = 2'b10;
         2'b11:   win = last ? 2'b01 : 2'b10;
         default: win = 2'b00;
      endcase
   end

endmodule

// File: rtl/axi4_lite_wr_arbiter.sv
// axi4_lite_wr_arbiter: shares one AXI4-Lite slave write port (AW, W, B)
// between two masters. Only one write is outstanding at a time. The grant
// is taken in IDLE and held until the B response handshake completes.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   m_aw*, m_w*, m_b*   two master write ports, master i in slice i
//   s_aw*, s_w*, s_b*   single slave write port
//   gnt                 one-hot grant, 2'b00 while idle
//   busy                high whenever a transaction is in progress
module axi4_lite_wr_arbiter
   import axi4_lite_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [2*ADDR_W-1:0]     m_awaddr,
   input  logic [5:0]              m_awprot,
   input  logic [1:0]              m_awvalid,
   output logic [1:0]              m_awready,
   input  logic [2*DATA_W-1:0]     m_wdata,
   input  logic [2*DATA_W/8-1:0]   m_wstrb,
   input  logic [1:0]              m_wvalid,
   output logic [1:0]              m_wready,
   output logic [3:0]              m_bresp,
   output logic [1:0]              m_bvalid,
   input  logic [1:0]              m_bready,
   output logic [ADDR_W-1:0]       s_awaddr,
   output logic [2:0]              s_awprot,
   output logic                    s_awvalid,
   input  logic                    s_awready,
   output logic [DATA_W-1:0]       s_wdata,
   output logic [DATA_W/8-1:0]     s_wstrb,
   output logic                    s_wvalid,
   input  logic                    s_wready,
   input  logic [1:0]              s_bresp,
   input  logic                    s_bvalid,
   output logic                    s_bready,
   output logic [1:0]              gnt,
   output logic                    busy
);

   localparam int STRB_W = DATA_W / 8;

   wr_state_e   state_r;
   logic [1:0]  gnt_r;
   logic        last_r;
   logic        aw_done_r;
   logic        w_done_r;
   logic        busy_r;

   logic [1:0]  req_s;
   logic [1:0]  win_s;
   logic        in_ad_s;
   logic        in_resp_s;
   logic        aw_hs_s;
   logic        w_hs_s;
   logic        b_hs_s;

   // W may arrive before AW, so either channel counts as a request.
   assign req_s = m_awvalid | m_wvalid;

   rr_arbiter2 u_rr (
      .req  (req_s),
      .last (last_r),
      .win  (win_s)
   );

   assign in_ad_s   = (state_r == ADDR_DATA);
   assign in_resp_s = (state_r == RESP);

   // Payload muxes are AND-OR gated by the one-hot grant, so the s_* payload
   // is zero while idle and a non-granted master never leaks through.
   assign s_awaddr = ({ADDR_W{gnt_r[0]}} & m_awaddr[ADDR_W-1:0])
                   | ({ADDR_W{gnt_r[1]}} & m_awaddr[2*ADDR_W-1:ADDR_W]);
   assign s_awprot = ({3{gnt_r[0]}} & m_awprot[2:0])
                   | ({3{gnt_r[1]}} & m_awprot[5:3]);
   assign s_wdata  = ({DATA_W{gnt_r[0]}} & m_wdata[DATA_W-1:0])
                   | ({DATA_W{gnt_r[1]}} & m_wdata[2*DATA_W-1:DATA_W]);
   assign s_wstrb  = ({STRB_W{gnt_r[0]}} & m_wstrb[STRB_W-1:0])
                   | ({STRB_W{gnt_r[1]}} & m_wstrb[2*STRB_W-1:STRB_W]);

   // Handshake qualifiers: AW/W only pass in ADDR_DATA, B only in RESP, and
   // a channel already accepted is masked so it cannot be issued twice.
   assign s_awvalid = in_ad_s & (|(m_awvalid & gnt_r)) & ~aw_done_r;
   assign m_awready = {2{in_ad_s & s_awready & ~aw_done_r}} & gnt_r;
   assign s_wvalid  = in_ad_s & (|(m_wvalid & gnt_r)) & ~w_done_r;
   assign m_wready  = {2{in_ad_s & s_wready & ~w_done_r}} & gnt_r;
   assign s_bready  = in_resp_s & (|(m_bready & gnt_r));
   assign m_bvalid  = {2{in_resp_s & s_bvalid}} & gnt_r;
   assign m_bresp   = {s_bresp, s_bresp};

   assign aw_hs_s = s_awvalid & s_awready;
   assign w_hs_s  = s_wvalid & s_wready;
   assign b_hs_s  = s_bvalid & s_bready;

   assign gnt  = gnt_r;
   assign busy = busy_r;

   // Arbitration FSM: grant in IDLE, track AW/W completion, release on B.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= IDLE;
         gnt_r     <= 2'b00;
         last_r    <= 1'b1;
         aw_done_r <= 1'b0;
         w_done_r  <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (|req_s) begin
                  gnt_r   <= win_s;
                  busy_r  <= 1'b1;
                  state_r <= ADDR_DATA;
               end
            end
            ADDR_DATA: begin
               if (aw_hs_s) begin
                  aw_done_r <= 1'b1;
               end
               if (w_hs_s) begin
                  w_done_r <= 1'b1;
               end
               // Covers AW and W completing in the same cycle as well as
               // the second one completing after the first.
               if ((aw_done_r | aw_hs_s) & (w_done_r | w_hs_s)) begin
                  state_r <= RESP;
               end
            end
            RESP: begin
               if (b_hs_s) begin
                  last_r    <= onehot_idx(gnt_r);
                  gnt_r     <= 2'b00;
                  aw_done_r <= 1'b0;
                  w_done_r  <= 1'b0;
                  busy_r    <= 1'b0;
                  state_r   <= IDLE;
               end
            end
            default: begin
               gnt_r     <= 2'b00;
               aw_done_r <= 1'b0;
               w_done_r  <= 1'b0;
               busy_r    <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/axi4_lite_wr_arbiter.md
Name: axi4_lite_wr_arbiter

Overview:
- Two-master to one-slave arbiter for the AXI4-Lite write path (AW, W and B channels).
- Placed between two AXI4_Lite_master instances and a single AXI4_Lite_slave, so that both masters share one slave write port.
- Round-robin grant with one outstanding write at a time.
- The grant is held from the address/data phase through to completion of the B response.

Parameters:
- ADDR_W, 32, address width of every AW channel.
- DATA_W, 32, data width of every W channel; the strobe width is DATA_W/8.

Ports:
clk  in  1  single system clock; all state is updated on its rising edge
reset  in  1  asynchronous, active-low reset (reset=0 resets the block)
m_awaddr  in  2*ADDR_W  master AW addresses; master i uses bits [i*ADDR_W +: ADDR_W]
m_awprot  in  2*3  master AW protection fields
m_awvalid  in  2  master AW valid, one bit per master
m_awready  out  2  master AW ready, one bit per master
m_wdata  in  2*DATA_W  master write data
m_wstrb  in  2*DATA_W/8  master write strobes
m_wvalid  in  2  master W valid
m_wready  out  2  master W ready
m_bresp  out  2*2  master B response; the slave response is copied to both slices
m_bvalid  out  2  master B valid
m_bready  in  2  master B ready
s_awaddr  out  ADDR_W  AW address to the slave, muxed from the granted master
s_awprot  out  3  AW protection field to the slave
s_awvalid  out  1  AW valid to the slave
s_awready  in  1  AW ready from the slave
s_wdata  out  DATA_W  W data to the slave
s_wstrb  out  DATA_W/8  W strobe to the slave
s_wvalid  out  1  W valid to the slave
s_wready  in  1  W ready from the slave
s_bresp  in  2  B response from the slave
s_bvalid  in  1  B valid from the slave
s_bready  out  1  B ready to the slave
gnt  out  2  one-hot current grant; 00 while idle
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; gnt=00, busy=0, last=1.
  - All valid and ready outputs are 0; the s_* payload outputs are 0.
- Requests:
  - req[i] = m_awvalid[i] | m_wvalid[i]. Either channel alone is a request, because W may precede AW.
- IDLE:
  - Every ready and valid output is 0.
  - If any req is high, pick a winner, register it into gnt, and go to ADDR_DATA.
  - Only one requester: that master wins.
  - Both requesting: the master other than `last` wins.
  - Grant latency is exactly one cycle after the request is first sampled.
- ADDR_DATA (granted master g):
  - s_awvalid = m_awvalid[g] & ~aw_done and m_awready[g] = s_awready & ~aw_done.
  - s_wvalid = m_wvalid[g] & ~w_done and m_wready[g] = s_wready & ~w_done.
  - Payload paths are combinational muxes selected by g.
  - aw_done is set on the AW handshake and w_done on the W handshake. They may be set in the same cycle and in either order.
  - The FSM goes to RESP in the cycle after both flags are set. This includes the case where both handshakes occur in the same cycle.
  - Non-granted masters see ready=0 and are stalled, never dropped.
- RESP:
  - s_bready = m_bready[g] and m_bvalid[g] = s_bvalid; m_bresp carries s_bresp.
  - On the B handshake: last<=g, gnt<=00, aw_done and w_done are cleared, and the FSM goes to IDLE.
  - A back-to-back request is re-arbitrated in IDLE, so there is a minimum of one idle cycle between transactions.
- Fairness: with both masters continuously requesting, grants strictly alternate 0,1,0,1. No master waits for more than one other transaction.
- The slave's AW/W handshake outputs are never asserted toward the slave while in IDLE or RESP.
- Reset mid-transaction: the FSM aborts to IDLE immediately and all valids drop. The partial transaction is lost; recovery is the system's responsibility.
- A slave that never returns B leaves the arbiter waiting in RESP with no timeout; this is intentional.
- Payload values from a non-granted master never propagate to the s_* outputs.

Decomposition:
- Shared package axi4_lite_pkg holds:
  - response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - the FSM state encoding IDLE=2'd0, ADDR_DATA=2'd1, RESP=2'd2.
- One natural sub-module, rr_arbiter2: combinational 2-requester round-robin pick from req and last, producing a one-hot winner. It can be reused later for the read-path arbiter.

Test Plan:
1. Reset held low for 4 cycles with m_awvalid=11 → gnt=00, busy=0, s_awvalid=0, all m_*ready=0. After release, master 0 is granted first (last=1).
2. Master 0 alone writes addr 0x6BBBBBBB, data 0x6BBBBBBB, strb 1111, prot 111; slave returns bresp=01 → s_* carry exactly these values, m_bresp[1:0]=01, m_bvalid=01, busy drops one cycle after the B handshake.
3. Both masters request continuously (M0 addr 0x10100111, M1 addr 0xCCCCCCCC) for 4 transactions → slave sees addresses in the order 0x10100111, 0xCCCCCCCC, 0x10100111, 0xCCCCCCCC.
4. Granted master asserts W two cycles before AW; slave holds s_awready low for 3 cycles → w_done is set first and RESP is entered only after the AW handshake. Exactly one AW and one W reach the slave.
5. Slave holds s_bvalid for 5 cycles while m_bready[g]=0 → FSM stays in RESP and gnt is unchanged. The other master's request stays stalled with m_awready=0.
6. reset pulsed low during ADDR_DATA after AW done but W pending → outputs zero immediately. After release, the pending master is re-arbitrated and its full transaction completes.
